apu_envelope: RTL and testbench
===============================

APU_ENVELOPE -- requirements
Module: apu_envelope

Interface
REQ-001 The block SHALL have parameter QUARTER_DIV, default 7457, giving clk cycles per quarter-frame tick (legal 2..65535).
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 apu__pulse_r  in  1  raw duty-cycle bit from the upstream pulse channel.
REQ-005 apu__pulse_r_vld  in  1  pulse bit valid.
REQ-006 apu__pulse_r_rdy  out  1  block accepts pulse bit this cycle.
REQ-007 apu__env_r  in  14  config: [3:0] volume/period V, [4] constant C, [5] loop/halt L, [13:6] length load N.
REQ-008 apu__env_r_vld  in  1  config valid.
REQ-009 apu__env_r_rdy  out  1  config accepted; SHALL be constant 1 outside reset.
REQ-010 apu__sample_s  out  4  scaled output sample to the mixer.
REQ-011 apu__sample_s_vld  out  1  sample valid.
REQ-012 apu__sample_s_rdy  in  1  mixer accepts sample.

Function
REQ-013 Transfer on any channel SHALL occur only in a cycle where vld and rdy are both 1.
REQ-014 Output stage SHALL be a one-entry register; apu__pulse_r_rdy = !sample_s_vld || apu__sample_s_rdy (same-cycle accept and drain allowed).
REQ-015 Accepted pulse bit SHALL appear on apu__sample_s with sample_s_vld the next cycle (latency 1); sample = (bit && !mute) ? vol : 0, mute and vol sampled in the accept cycle.
REQ-016 While sample_s_vld=1 and sample_s_rdy=0, apu__sample_s and vld SHALL hold stable.
REQ-017 vol SHALL equal V when C=1, else decay counter D (4 bits).
REQ-018 Tick counter SHALL count 0..QUARTER_DIV-1 and wrap, emitting a one-cycle quarter tick at wrap; every second quarter tick SHALL also be a half tick.
REQ-019 Config accept SHALL latch V, C, L, set start flag S; config write and tick in the same cycle: new config latched, tick processed with old V/C/L and old S, new S survives.
REQ-020 Envelope on quarter tick: if S, then S=0, D=15, divider=V; else if divider==0, divider=V and (D>0 ? D-1 : (L ? 15 : 0)); else divider-1.
REQ-021 D=0 with L=0 SHALL stay 0 (no wrap); D=0 with L=1 SHALL reload 15.
REQ-022 Envelope state SHALL not depend on pulse/sample handshake; stalls never freeze ticks.

Reset
REQ-023 While reset=1: sample_s_vld=0, apu__sample_s=0, pulse_r_rdy=0, env_r_rdy=0; D, divider, S, V, C, L, tick/half counters, length counter SHALL be 0.
REQ-024 Reset asserted mid-transfer SHALL discard the buffered sample; first valid sample after release requires a new pulse accept.

Configuration
REQ-025 Macro APU_LENGTH_COUNTER_EN SHALL compile in an 8-bit length counter LC.
REQ-026 With it: config accept loads LC=N; on half tick, LC decrements if LC>0 and L=0; mute = (LC==0); config write wins over same-cycle decrement.
REQ-027 Without it: env bits [13:6] ignored, no LC state, mute constant 0; other behaviour identical.

Verification
REQ-028 Reset, then pulse=1 vld with sample_rdy=1, no config -> sample 0 one cycle later (D=0, C=0).
REQ-029 QUARTER_DIV=4, config V=2 C=0 L=0 -> after first tick D=15, then D decrements every 3 ticks to 0 and holds; pulse=1 samples track D.
REQ-030 Same with L=1 -> D=0 then reloads 15 at next divider expiry.
REQ-031 C=1 V=9, pulse stream 1,0,1 with sample_rdy low 3 cycles on 2nd -> outputs 9,0,9 in order, held stable while stalled, no loss.
REQ-032 APU_LENGTH_COUNTER_EN, QUARTER_DIV=4, C=1 V=15 N=2 L=0 -> samples 15 until second half tick, then 0; repeat with L=1 -> never muted.
REQ-033 Assert reset for 1 cycle while sample_s_vld=1 stalled -> vld=0 next cycle, all state zero.

Source files
------------

// File: rtl/apu_envelope.sv
`default_nettype none
// ============================================================================
//  Module   : apu_envelope
//  Purpose  : Pulse-channel volume envelope. A quarter-frame divider clocks a
//             4-bit decay envelope; accepted duty-cycle bits are scaled by the
//             current volume into a one-entry valid/ready output register.
//  Optional : `define APU_LENGTH_COUNTER_EN adds an 8-bit length counter that
//             mutes the output when it reaches zero (clocked on half ticks).
//  Ports    :
//    clk, reset           - clock, synchronous active-high reset
//    apu__pulse_r[_vld/_rdy]  - raw duty bit in (valid/ready)
//    apu__env_r[_vld/_rdy]    - config in: [3:0] V, [4] C, [5] L, [13:6] N
//    apu__sample_s[_vld/_rdy] - 4-bit scaled sample out (valid/ready)
//  Parameter: QUARTER_DIV - clk cycles per quarter-frame tick (2..65535)
//  Revision : 1.0 - initial release
// ============================================================================
module apu_envelope #(
  parameter int QUARTER_DIV = 7457
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        apu__pulse_r,
  input  logic        apu__pulse_r_vld,
  output logic        apu__pulse_r_rdy,
  input  logic [13:0] apu__env_r,
  input  logic        apu__env_r_vld,
  output logic        apu__env_r_rdy,
  output logic [3:0]  apu__sample_s,
  output logic        apu__sample_s_vld,
  input  logic        apu__sample_s_rdy
);

  localparam logic [15:0] TICK_LAST = 16'(QUARTER_DIV - 1);

  logic [15:0] tick_cnt;
  logic        half_phase;
  logic        quarter_tick;
  logic        half_tick;

  logic [3:0]  env_v;
  logic        env_c;
  logic        env_l;
  logic        start;
  logic [3:0]  decay;
  logic [3:0]  divider;

  logic [3:0]  smp;
  logic        smp_vld;

  logic        env_acc;
  logic        pulse_acc;
  logic        mute;
  logic [3:0]  vol;

  assign quarter_tick = (tick_cnt == TICK_LAST);
  // Every second quarter tick doubles as a half tick.
  assign half_tick    = quarter_tick && half_phase;

  assign apu__env_r_rdy   = !reset;
  assign apu__pulse_r_rdy = !reset && (!smp_vld || apu__sample_s_rdy);
  assign env_acc          = apu__env_r_vld && apu__env_r_rdy;
  assign pulse_acc        = apu__pulse_r_vld && apu__pulse_r_rdy;

  assign vol = env_c ? env_v : decay;

  // Outputs are forced low while reset is held, not just after the edge.
  assign apu__sample_s_vld = smp_vld && !reset;
  assign apu__sample_s     = reset ? 4'd0 : smp;

  // Free-running quarter-frame divider; never gated by the handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt   <= '0;
      half_phase <= 1'b0;
    end else if (quarter_tick) begin
      tick_cnt   <= '0;
      half_phase <= ~half_phase;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  // Envelope. The tick branch reads the pre-write V/L/S; the config branch
  // comes last so a same-cycle write leaves start set for the next tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      env_v   <= '0;
      env_c   <= 1'b0;
      env_l   <= 1'b0;
      start   <= 1'b0;
      decay   <= '0;
      divider <= '0;
    end else begin
      if (quarter_tick) begin
        if (start) begin
          start   <= 1'b0;
          decay   <= 4'd15;
          divider <= env_v;
        end else if (divider == 4'd0) begin
          divider <= env_v;
          if (decay != 4'd0) begin
            decay <= decay - 4'd1;
          end else if (env_l) begin
            decay <= 4'd15;
          end
        end else begin
          divider <= divider - 4'd1;
        end
      end
      if (env_acc) begin
        env_v <= apu__env_r[3:0];
        env_c <= apu__env_r[4];
        env_l <= apu__env_r[5];
        start <= 1'b1;
      end
    end
  end

`ifdef APU_LENGTH_COUNTER_EN
  logic [7:0] len_cnt;

  // A config load takes priority over a same-cycle half-tick decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_cnt <= '0;
    end else if (env_acc) begin
      len_cnt <= apu__env_r[13:6];
    end else if (half_tick && (len_cnt != 8'd0) && !env_l) begin
      len_cnt <= len_cnt - 8'd1;
    end
  end

  assign mute = (len_cnt == 8'd0);
`else
  logic unused_len;
  assign unused_len = ^{apu__env_r[13:6], half_tick};
  assign mute       = 1'b0;
`endif

  // One-entry output register; accept and drain may share a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      smp_vld <= 1'b0;
      smp     <= '0;
    end else if (pulse_acc) begin
      smp_vld <= 1'b1;
      smp     <= (apu__pulse_r && !mute) ? vol : 4'd0;
    end else if (apu__sample_s_rdy) begin
      smp_vld <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apu_envelope.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apu_envelope
//  Purpose  : Scoreboard bench for apu_envelope with QUARTER_DIV=4. Stimulus
//             pushes the expected sample when a pulse is accepted; a monitor
//             pops and compares whenever a sample transfers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apu_envelope;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pulse = 1'b0;
  logic        pulse_vld = 1'b0;
  logic        pulse_rdy;
  logic [13:0] env = '0;
  logic        env_vld = 1'b0;
  logic        env_rdy;
  logic [3:0]  sample;
  logic        sample_vld;
  logic        sample_rdy = 1'b1;

  apu_envelope #(.QUARTER_DIV(QD)) dut (
    .clk               (clk),
    .reset             (reset),
    .apu__pulse_r      (pulse),
    .apu__pulse_r_vld  (pulse_vld),
    .apu__pulse_r_rdy  (pulse_rdy),
    .apu__env_r        (env),
    .apu__env_r_vld    (env_vld),
    .apu__env_r_rdy    (env_rdy),
    .apu__sample_s     (sample),
    .apu__sample_s_vld (sample_vld),
    .apu__sample_s_rdy (sample_rdy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ecount  = 0;    // posedges since reset release
  int exp_q[$];

  // Model of the last written config and the edge that accepted it.
  int cfg_v = 0, cfg_l = 0, cfg_n = 0, cfg_e = 0;
  bit cfg_c = 1'b1;

  bit stalled = 1'b0;
  int held    = 0;

  always @(posedge clk) begin
    if (reset) ecount <= 0;
    else       ecount <= ecount + 1;
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected sample for a pulse accepted at the edge following ecount==now.
  // Decay is written in closed form: 15 at the first tick after a config,
  // then one step down every V+1 ticks.
  function automatic int exp_sample(input logic b, input int now);
    int vol, t, n, h, lc;
    if (cfg_c) begin
      vol = cfg_v;
    end else begin
      t = now / QD - cfg_e / QD;
      if (t <= 0) begin
        vol = 0;
      end else begin
        n = (t - 1) / (cfg_v + 1);
        if (cfg_l != 0) vol = 15 - (n % 16);
        else            vol = (n >= 15) ? 0 : 15 - n;
      end
    end
`ifdef APU_LENGTH_COUNTER_EN
    h  = now / (2 * QD) - cfg_e / (2 * QD);
    lc = (cfg_l != 0) ? cfg_n : ((cfg_n - h > 0) ? cfg_n - h : 0);
    if (lc == 0) vol = 0;
`else
    h  = 0;
    lc = h;
`endif
    return b ? vol : 0;
  endfunction

  // Monitor: compares each transferred sample and stability while stalled.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("hold_vld", int'(sample_vld), 1);
          check("hold_data", int'(sample), held);
        end
        if (sample_vld && sample_rdy) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_sample: got %0d expected none", sample);
          end else begin
            e = exp_q.pop_front();
            check("sample", int'(sample), e);
          end
          stalled = 1'b0;
        end else if (sample_vld) begin
          stalled = 1'b1;
          held    = int'(sample);
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  // Call at a falling edge; returns at the falling edge after acceptance.
  task automatic send_pulse(input logic b);
    int  waited = 0;
    bit  ok = 1'b0;
    pulse     = b;
    pulse_vld = 1'b1;
    forever begin
      #2;
      if (pulse_rdy) begin
        ok = 1'b1;
        break;
      end
      waited++;
      if (waited > 50) break;
      @(negedge clk);
    end
    if (ok) begin
      exp_q.push_back(exp_sample(b, ecount));
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL pulse_timeout: got no ready expected ready within 50 cycles");
    end
    @(negedge clk);
    pulse_vld = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset     = 1'b1;
    pulse_vld = 1'b0;
    env_vld   = 1'b0;
    exp_q.delete();
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  // Present a config so it is accepted at the edge where ecount becomes k.
  task automatic cfg_at(input int k, input int v, input bit c, input int l, input int n);
    int guard = 0;
    while (ecount != k - 1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    env     = {8'(n), 1'(l), c, 4'(v)};
    env_vld = 1'b1;
    cfg_v = v; cfg_c = c; cfg_l = l; cfg_n = n; cfg_e = k;
    @(negedge clk);
    env_vld = 1'b0;
  endtask

  initial begin
    int guard;

    // Reset state with all inputs active.
    pulse = 1'b1; pulse_vld = 1'b1; env = 14'h3fff; env_vld = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("rst_sample_vld", int'(sample_vld), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_pulse_rdy", int'(pulse_rdy), 0);
    check("rst_env_rdy", int'(env_rdy), 0);

    do_reset(2);
    #1;
    check("env_rdy_idle", int'(env_rdy), 1);

    // No config after reset: D=0, C=0 -> sample 0, one cycle latency.
    @(negedge clk);
    cfg_c = 1'b1; cfg_v = 0; cfg_l = 0; cfg_n = 0; cfg_e = 0;
    send_pulse(1'b1);
    check("latency_vld", int'(sample_vld), 1);

    // Decay without loop: 15, then down every 3 ticks, holds at 0.
    do_reset(2);
    cfg_at(5, 2, 1'b0, 0, 255);
    for (int i = 0; i < 230; i++) send_pulse(i % 5 != 0);

    // Decay with loop: reloads 15 after reaching 0.
    do_reset(2);
    cfg_at(5, 2, 1'b0, 1, 255);
    for (int i = 0; i < 260; i++) send_pulse(i % 7 != 3);

    // Constant volume 9, stream 1,0,1 with a 3-cycle stall on the 2nd.
    do_reset(2);
    cfg_at(5, 9, 1'b1, 0, 255);
    send_pulse(1'b1);
    send_pulse(1'b0);
    fork
      begin
        sample_rdy = 1'b0;
        #2;
        check("pulse_rdy_stall", int'(pulse_rdy), 0);
        repeat (3) @(negedge clk);
        sample_rdy = 1'b1;
      end
      send_pulse(1'b1);
    join
    repeat (3) @(negedge clk);

`ifdef APU_LENGTH_COUNTER_EN
    // Length counter N=2: muted from the second half tick unless L=1.
    do_reset(2);
    cfg_at(5, 15, 1'b1, 0, 2);
    for (int i = 0; i < 40; i++) send_pulse(1'b1);
    do_reset(2);
    cfg_at(5, 15, 1'b1, 1, 2);
    for (int i = 0; i < 40; i++) send_pulse(1'b1);
`endif

    // One-cycle reset while a sample is stalled discards it.
    do_reset(2);
    cfg_at(5, 9, 1'b1, 0, 255);
    sample_rdy = 1'b0;
    send_pulse(1'b1);
    check("stall_vld_before_rst", int'(sample_vld), 1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_vld", int'(sample_vld), 0);
    check("rst_mid_sample", int'(sample), 0);
    @(negedge clk);
    check("rst_mid_vld_idle", int'(sample_vld), 0);
    sample_rdy = 1'b1;
    cfg_c = 1'b1; cfg_v = 0; cfg_l = 0; cfg_n = 0; cfg_e = 0;
    send_pulse(1'b1);

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #3;
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
